// File: rtl/t_latch.sv
// -----------------------------------------------------------------------------
// t_latch -- clocked, vector-capable toggle storage element.
//
// Each bit of q inverts on a rising clk edge when its T bit is 1 and holds
// otherwise. T is sampled only at the rising edge; there is no
// level-transparent path. qn is the bitwise complement of the q register.
//
// Optional feature macro: T_LATCH_TOGGLE_CNT_EN
//   When defined, the toggle_cnt port and a saturating counter are added.
//   The counter increments once per edge on which any T bit is set, so it
//   counts cycles rather than bits.
//
// Parameters
//   WIDTH      number of independent toggle bits (>= 1)
//   RESET_VAL  value loaded into q while reset is asserted
//   CNT_W      toggle-counter width (only used with T_LATCH_TOGGLE_CNT_EN)
//
// Ports
//   clk         in   1       single clock, rising-edge active
//   reset       in   1       synchronous active-low reset (0 = reset)
//   T           in   WIDTH   per-bit toggle request
//   q           out  WIDTH   stored state, registered
//   qn          out  WIDTH   ~q, derived directly from the q register
//   toggle_cnt  out  CNT_W   toggle-cycle count (only with the macro defined)
// -----------------------------------------------------------------------------
module t_latch #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
`ifdef T_LATCH_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt
`endif
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  // Next-state for the toggle bits: invert exactly the bits requested by T.
  always_comb begin
    state_d = state_q ^ T;
  end

  // Toggle state register; reset takes priority over any toggle request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign q  = state_q;
  // qn stays the exact complement of q, including straight after reset.
  assign qn = ~state_q;

`ifdef T_LATCH_TOGGLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating counter of edges on which at least one bit toggles.
  always_comb begin
    cnt_d = cnt_q;
    if ((|T) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared by the same synchronous reset as q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign toggle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_t_latch.sv
// -----------------------------------------------------------------------------
// tb_t_latch -- self-checking bench for t_latch.
//
// dut1: WIDTH=1, RESET_VAL=0, CNT_W=2 (counter checked when
//       T_LATCH_TOGGLE_CNT_EN is defined).
// dut4: WIDTH=4, RESET_VAL=4'b1010 for the multi-bit mid-stream reset case.
// -----------------------------------------------------------------------------
module tb_t_latch;

  logic       clk;
  logic       reset1;
  logic [0:0] t1;
  logic [0:0] q1;
  logic [0:0] qn1;
  logic       reset4;
  logic [3:0] t4;
  logic [3:0] q4;
  logic [3:0] qn4;
`ifdef T_LATCH_TOGGLE_CNT_EN
  logic [1:0] cnt1;
`endif

  int total_cnt;
  int pass_cnt;

  t_latch #(
    .WIDTH    (1),
    .RESET_VAL(1'b0),
    .CNT_W    (2)
  ) dut1 (
    .clk  (clk),
    .reset(reset1),
    .T    (t1),
    .q    (q1),
    .qn   (qn1)
`ifdef T_LATCH_TOGGLE_CNT_EN
    ,
    .toggle_cnt(cnt1)
`endif
  );

  t_latch #(
    .WIDTH    (4),
    .RESET_VAL(4'b1010),
    .CNT_W    (8)
  ) dut4 (
    .clk  (clk),
    .reset(reset4),
    .T    (t4),
    .q    (q4),
    .qn   (qn4)
`ifdef T_LATCH_TOGGLE_CNT_EN
    ,
    .toggle_cnt()
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [0:0] t;
    logic [0:0] exp_q;
    string      name;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    reset1 = 1'b0;
    t1     = 1'b0;
    reset4 = 1'b0;
    t4     = 4'b0000;

    // reset with T=1, hold, toggle, reset priority, release mid-stream
    vecs[0]  = '{1'b0, 1'b1, 1'b0, "reset_t_ignored"};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, "hold1"};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, "hold2"};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, "hold3"};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, "hold4"};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, "hold5"};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, "toggle1"};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, "toggle2"};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, "toggle3"};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, "toggle4"};
    vecs[10] = '{1'b1, 1'b1, 1'b1, "toggle5"};
    vecs[11] = '{1'b0, 1'b1, 1'b0, "reset_priority"};
    vecs[12] = '{1'b1, 1'b1, 1'b1, "release_applies_t"};
    vecs[13] = '{1'b1, 1'b0, 1'b1, "hold_at_one"};
    vecs[14] = '{1'b0, 1'b0, 1'b0, "reset_from_one"};
    vecs[15] = '{1'b0, 1'b0, 1'b0, "reset_held"};
    vecs[16] = '{1'b1, 1'b1, 1'b1, "release_toggle"};

    #2;
    for (int i = 0; i < 17; i++) begin
      reset1 = vecs[i].rst;
      t1     = vecs[i].t;
      step();
      check({vecs[i].name, "_q"},  {31'd0, q1},  {31'd0, vecs[i].exp_q});
      check({vecs[i].name, "_qn"}, {31'd0, qn1}, {31'd0, ~vecs[i].exp_q});
    end

    // q is 1 here. T pulsed only between edges must not toggle.
    for (int i = 0; i < 3; i++) begin
      reset1 = 1'b1;
      t1     = 1'b0;
      #2 t1 = 1'b1;
      #3 t1 = 1'b0;
      step();
      check("between_edge_pulse_q", {31'd0, q1}, 32'd1);
    end

    // Reset asserted between edges leaves q alone until the next edge.
    reset1 = 1'b0;
    t1     = 1'b0;
    #2;
    check("sync_reset_no_async_q",  {31'd0, q1},  32'd1);
    check("sync_reset_no_async_qn", {31'd0, qn1}, 32'd0);
    step();
    check("sync_reset_edge_q", {31'd0, q1}, 32'd0);

    // Multi-bit mid-stream reset with non-zero RESET_VAL.
    reset4 = 1'b0;
    t4     = 4'b0101;
    step();
    check("w4_reset_q",  {28'd0, q4},  {28'd0, 4'b1010});
    check("w4_reset_qn", {28'd0, qn4}, {28'd0, 4'b0101});
    reset4 = 1'b1;
    t4     = 4'b0110;
    step();
    check("w4_toggle_q",  {28'd0, q4},  {28'd0, 4'b1100});
    check("w4_toggle_qn", {28'd0, qn4}, {28'd0, 4'b0011});
    t4 = 4'b0011;
    step();
    check("w4_toggle2_q", {28'd0, q4}, {28'd0, 4'b1111});
    reset4 = 1'b0;
    t4     = 4'b1111;
    step();
    check("w4_midreset_q",  {28'd0, q4},  {28'd0, 4'b1010});
    check("w4_midreset_qn", {28'd0, qn4}, {28'd0, 4'b0101});

`ifdef T_LATCH_TOGGLE_CNT_EN
    // Saturating toggle-cycle counter, CNT_W=2.
    reset1 = 1'b0;
    t1     = 1'b0;
    step();
    check("cnt_reset", {30'd0, cnt1}, 32'd0);
    reset1 = 1'b1;
    t1     = 1'b0;
    step();
    check("cnt_hold_t0", {30'd0, cnt1}, 32'd0);
    t1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("cnt_sat_seq", {30'd0, cnt1}, (i < 3) ? (i + 1) : 3);
    end
    reset1 = 1'b0;
    step();
    check("cnt_reset_after_sat", {30'd0, cnt1}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
